alu_result_checker: RTL and testbench
=====================================

Name: alu_result_checker

Overview:
- Synthesizable self-checking monitor for the 6-bit ALU.
- Sits on the ALU's input/output bus and independently recomputes the expected Result/CarryOut for each valid transaction. It flags mismatches, counts passes, failures and illegal opcodes, and captures the first failing transaction.
- It is the receiving end of the ALU stimulus path: benches and on-chip self-test drive operations, and this block judges them.

Parameters:
- WIDTH, 6, operand/result width
- CNT_W, 8, width of pass/error/illegal counters (saturating)
- HALT_ON_ERROR, 0, 1 = stop checking after first failure

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = accept transactions; 0 = ignore in_valid
- clear  input  1  synchronous clear of counters, capture and HALTED state
- in_valid  input  1  transaction present this cycle
- ALUOp  input  4  operation code driven to the ALU
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- CarryIn  input  1  carry input driven to the ALU
- Result  input  WIDTH  ALU result for the same transaction (same cycle)
- CarryOut  input  1  ALU carry out (same cycle)
- chk_valid  output  1  verdict strobe
- chk_pass  output  1  verdict; meaningful only when chk_valid=1
- pass_count  output  CNT_W  passing transactions
- err_count  output  CNT_W  failing transactions
- illegal_count  output  CNT_W  transactions with unsupported ALUOp
- fail_seen  output  1  sticky; first failure captured
- fail_op  output  4  ALUOp of first failure
- fail_a  output  WIDTH  a of first failure
- fail_b  output  WIDTH  b of first failure
- fail_result  output  WIDTH  observed Result of first failure
- halted  output  1  1 in HALTED state

Behaviour:
- Reset: all outputs 0; state IDLE; pipeline valid bits 0.
- Opcode table, expected values:
  - 0000 AND: a&b; CarryOut not checked.
  - 0001 OR: a|b; CarryOut not checked.
  - 0010 ADD: {CarryOut,Result} = a+b+CarryIn.
  - 0110 SUB: {CarryOut,Result} = a+~b+CarryIn, computed in WIDTH+1 bits. The caller supplies CarryIn=1 for a true subtract.
  - 1100 NOR: ~(a|b); CarryOut not checked.
- Any other ALUOp is illegal: illegal_count increments, chk_valid stays 0, and the transaction is neither pass nor fail.
- State machine:
  - IDLE -> CHECKING when enable=1.
  - CHECKING -> IDLE when enable=0. Transactions already in the pipeline still complete.
  - CHECKING -> HALTED on a failing verdict when HALT_ON_ERROR=1.
  - HALTED -> IDLE on clear. reset returns to IDLE from any state.
- Transactions are accepted only in CHECKING with in_valid=1.
- Pipeline, latency 2:
  - Stage 1 registers the transaction, the expected values and the legal flag on the acceptance edge.
  - Stage 2 compares and registers the verdict. chk_valid/chk_pass are high for exactly one cycle, 2 clocks after acceptance.
  - Throughput 1 transaction per cycle; back-to-back verdicts are contiguous.
- Counters:
  - pass_count/err_count/illegal_count increment in the same cycle their verdict or illegal flag registers.
  - Counters saturate at 2^CNT_W-1, with no wrap.
- First-failure capture: on the first failing verdict, fail_seen=1 and fail_op/fail_a/fail_b/fail_result latch. Later failures leave the capture unchanged until clear or reset.
- HALTED: new in_valid is ignored. An in-flight stage-1 transaction still produces its verdict and updates counters; no further captures occur.
- clear: synchronous, one cycle. Zeroes counters and capture, drops in-flight valids and sends HALTED to IDLE.
- Simultaneous events:
  - reset dominates clear.
  - clear dominates an increment in the same cycle, so the counter reads 0.
- enable low mid-stream: no new accepts; the pipeline drains normally.
- Reset mid-operation: in-flight transactions are discarded with no verdict.

Test Plan:
- a=1, b=2, CarryIn=0; AND, OR, NOR with Result 0, 3, 60 -> three chk_pass=1 strobes at +2 cycles each; pass_count=3; err_count=0.
- a=1, b=2: ADD CarryIn=0, Result=3, CarryOut=0; ADD CarryIn=1, Result=4, CarryOut=0; SUB CarryIn=1, Result=63, CarryOut=0 -> all pass.
- a=63, b=1, ADD CarryIn=0, Result=0, CarryOut=0 (wrong carry) -> chk_pass=0; err_count=1; fail_seen=1; fail_op=0010; fail_a=63; fail_b=1; fail_result=0. A second failure leaves the capture unchanged.
- ALUOp=0111 with in_valid -> illegal_count=1; no chk_valid strobe; pass and err counters unchanged.
- HALT_ON_ERROR=1: fail, then 5 more valid transactions -> halted=1; counters frozen except the one in-flight verdict. clear -> all counters 0, halted=0, state IDLE.
- CNT_W=2, 5 passing transactions -> pass_count holds 3. reset asserted with 2 transactions in flight -> no chk_valid afterwards; all outputs 0.

Source files
------------

// File: rtl/alu_result_checker.sv
// Self-checking monitor for the 6-bit ALU. Recomputes Result/CarryOut for each
// accepted transaction, emits a verdict two clocks later, and captures the first failure.
module alu_result_checker #(
   parameter int WIDTH         = 6,
   parameter int CNT_W         = 8,
   parameter bit HALT_ON_ERROR = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [3:0]       ALUOp,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             CarryIn,
   input  logic [WIDTH-1:0] Result,
   input  logic             CarryOut,
   output logic             chk_valid,
   output logic             chk_pass,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] illegal_count,
   output logic             fail_seen,
   output logic [3:0]       fail_op,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH-1:0] fail_result,
   output logic             halted,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CHECKING = 2'd1,
      S_HALTED   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   state_t           state_next;
   logic             accept;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_sum;
   logic [WIDTH-1:0] exp_result;
   logic             exp_carry;
   logic             check_carry;
   logic             op_legal;

   logic             s1_valid;
   logic [3:0]       s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] s1_result;
   logic             s1_carry;
   logic [WIDTH-1:0] s1_exp_result;
   logic             s1_exp_carry;
   logic             s1_check_carry;
   logic             mismatch;
   logic             verdict_fail;

   // Handshake: in_valid has no backpressure; a transaction is taken on any
   // edge where accept is high, and chk_valid is a one-cycle strobe per verdict.

   assign add_sum = {1'b0, a} + {1'b0, b}  + {{WIDTH{1'b0}}, CarryIn};
   assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, CarryIn};

   always_comb begin
      exp_result  = '0;
      exp_carry   = 1'b0;
      check_carry = 1'b0;
      op_legal    = 1'b1;
      case (ALUOp)
         4'b0000: exp_result = a & b;
         4'b0001: exp_result = a | b;
         4'b0010: begin
            exp_result  = add_sum[WIDTH-1:0];
            exp_carry   = add_sum[WIDTH];
            check_carry = 1'b1;
         end
         4'b0110: begin
            exp_result  = sub_sum[WIDTH-1:0];
            exp_carry   = sub_sum[WIDTH];
            check_carry = 1'b1;
         end
         4'b1100: exp_result = ~(a | b);
         default: op_legal = 1'b0;
      endcase
   end

   assign mismatch     = (s1_result != s1_exp_result) ||
                         (s1_check_carry && (s1_carry != s1_exp_carry));
   // A clear in the same cycle drops the stage-1 transaction, so it cannot halt.
   assign verdict_fail = s1_valid && mismatch && !clear;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:     if (enable) state_next = S_CHECKING;
         S_CHECKING: begin
            if (HALT_ON_ERROR && verdict_fail) state_next = S_HALTED;
            else if (!enable)                  state_next = S_IDLE;
         end
         S_HALTED:   if (clear) state_next = S_IDLE;
         default:    state_next = S_IDLE;
      endcase
   end

   always_comb begin
      halted    = (state == S_HALTED);
      accept    = (state == S_CHECKING) && enable && in_valid;
      fsm_state = state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid       <= 1'b0;
         s1_op          <= '0;
         s1_a           <= '0;
         s1_b           <= '0;
         s1_result      <= '0;
         s1_carry       <= 1'b0;
         s1_exp_result  <= '0;
         s1_exp_carry   <= 1'b0;
         s1_check_carry <= 1'b0;
         chk_valid      <= 1'b0;
         chk_pass       <= 1'b0;
         pass_count     <= '0;
         err_count      <= '0;
         illegal_count  <= '0;
         fail_seen      <= 1'b0;
         fail_op        <= '0;
         fail_a         <= '0;
         fail_b         <= '0;
         fail_result    <= '0;
      end else if (clear) begin
         s1_valid      <= 1'b0;
         chk_valid     <= 1'b0;
         chk_pass      <= 1'b0;
         pass_count    <= '0;
         err_count     <= '0;
         illegal_count <= '0;
         fail_seen     <= 1'b0;
         fail_op       <= '0;
         fail_a        <= '0;
         fail_b        <= '0;
         fail_result   <= '0;
      end else begin
         s1_valid <= accept && op_legal;
         if (accept) begin
            s1_op          <= ALUOp;
            s1_a           <= a;
            s1_b           <= b;
            s1_result      <= Result;
            s1_carry       <= CarryOut;
            s1_exp_result  <= exp_result;
            s1_exp_carry   <= exp_carry;
            s1_check_carry <= check_carry;
         end
         if (accept && !op_legal && illegal_count != CNT_MAX)
            illegal_count <= illegal_count + CNT_ONE;

         chk_valid <= s1_valid;
         chk_pass  <= s1_valid && !mismatch;
         if (s1_valid) begin
            if (!mismatch) begin
               if (pass_count != CNT_MAX) pass_count <= pass_count + CNT_ONE;
            end else begin
               if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
               // Only the first failure is kept, and nothing is captured once halted.
               if (!fail_seen && state != S_HALTED) begin
                  fail_seen   <= 1'b1;
                  fail_op     <= s1_op;
                  fail_a      <= s1_a;
                  fail_b      <= s1_b;
                  fail_result <= s1_result;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: three instances (default, halt-on-error, 2-bit
// counters) driven one at a time and compared every cycle against a reference model.
module tb_alu_result_checker;

   localparam int W   = 6;
   localparam int MOD = 1 << W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset = 1'b1;
   logic         clear = 1'b0;
   logic         enable = 1'b0;
   logic         in_valid = 1'b0;
   logic [3:0]   ALUOp = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         CarryIn = 1'b0;
   logic [W-1:0] Result = '0;
   logic         CarryOut = 1'b0;
   logic [1:0]   sel = 2'd0;
   logic         en0, en1, en2;

   assign en0 = enable && (sel == 2'd0);
   assign en1 = enable && (sel == 2'd1);
   assign en2 = enable && (sel == 2'd2);

   logic         cv[3], cp[3], fs[3], hl[3];
   logic [3:0]   fop[3];
   logic [W-1:0] fa[3], fb[3], fr[3];
   logic [1:0]   st[3];
   logic [7:0]   pc[2], ec[2], ic[2];
   logic [1:0]   pc_s, ec_s, ic_s;

   alu_result_checker #(.WIDTH(W), .CNT_W(8), .HALT_ON_ERROR(1'b0)) dut_main (
      .clk(clk), .reset(reset), .enable(en0), .clear(clear), .in_valid(in_valid),
      .ALUOp(ALUOp), .a(a), .b(b), .CarryIn(CarryIn), .Result(Result), .CarryOut(CarryOut),
      .chk_valid(cv[0]), .chk_pass(cp[0]), .pass_count(pc[0]), .err_count(ec[0]),
      .illegal_count(ic[0]), .fail_seen(fs[0]), .fail_op(fop[0]), .fail_a(fa[0]),
      .fail_b(fb[0]), .fail_result(fr[0]), .halted(hl[0]), .fsm_state(st[0]));

   alu_result_checker #(.WIDTH(W), .CNT_W(8), .HALT_ON_ERROR(1'b1)) dut_halt (
      .clk(clk), .reset(reset), .enable(en1), .clear(clear), .in_valid(in_valid),
      .ALUOp(ALUOp), .a(a), .b(b), .CarryIn(CarryIn), .Result(Result), .CarryOut(CarryOut),
      .chk_valid(cv[1]), .chk_pass(cp[1]), .pass_count(pc[1]), .err_count(ec[1]),
      .illegal_count(ic[1]), .fail_seen(fs[1]), .fail_op(fop[1]), .fail_a(fa[1]),
      .fail_b(fb[1]), .fail_result(fr[1]), .halted(hl[1]), .fsm_state(st[1]));

   alu_result_checker #(.WIDTH(W), .CNT_W(2), .HALT_ON_ERROR(1'b0)) dut_sat (
      .clk(clk), .reset(reset), .enable(en2), .clear(clear), .in_valid(in_valid),
      .ALUOp(ALUOp), .a(a), .b(b), .CarryIn(CarryIn), .Result(Result), .CarryOut(CarryOut),
      .chk_valid(cv[2]), .chk_pass(cp[2]), .pass_count(pc_s), .err_count(ec_s),
      .illegal_count(ic_s), .fail_seen(fs[2]), .fail_op(fop[2]), .fail_a(fa[2]),
      .fail_b(fb[2]), .fail_result(fr[2]), .halted(hl[2]), .fsm_state(st[2]));

   // Outputs of the instance under test
   logic         o_cv, o_cp, o_fs, o_hl;
   logic [3:0]   o_fop;
   logic [W-1:0] o_fa, o_fb, o_fr;
   logic [7:0]   o_pc, o_ec, o_ic;

   always_comb begin
      o_cv = 1'b0; o_cp = 1'b0; o_fs = 1'b0; o_hl = 1'b0;
      o_fop = '0; o_fa = '0; o_fb = '0; o_fr = '0;
      o_pc = '0; o_ec = '0; o_ic = '0;
      case (sel)
         2'd0: begin
            o_cv = cv[0]; o_cp = cp[0]; o_fs = fs[0]; o_hl = hl[0];
            o_fop = fop[0]; o_fa = fa[0]; o_fb = fb[0]; o_fr = fr[0];
            o_pc = pc[0]; o_ec = ec[0]; o_ic = ic[0];
         end
         2'd1: begin
            o_cv = cv[1]; o_cp = cp[1]; o_fs = fs[1]; o_hl = hl[1];
            o_fop = fop[1]; o_fa = fa[1]; o_fb = fb[1]; o_fr = fr[1];
            o_pc = pc[1]; o_ec = ec[1]; o_ic = ic[1];
         end
         default: begin
            o_cv = cv[2]; o_cp = cp[2]; o_fs = fs[2]; o_hl = hl[2];
            o_fop = fop[2]; o_fa = fa[2]; o_fb = fb[2]; o_fr = fr[2];
            o_pc = {6'd0, pc_s}; o_ec = {6'd0, ec_s}; o_ic = {6'd0, ic_s};
         end
      endcase
   end

   // ---------------- scoreboard / reference model ----------------
   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      bit         pass;
      logic [3:0] op;
      int         av, bv, res;
   } txn_t;

   txn_t exp_q[$];
   int   m_st;            // 0 idle, 1 checking, 2 halted
   bit   m_halt;
   int   m_max;
   bit   exp_cv, exp_cp, exp_fs;
   int   exp_pc, exp_ec, exp_ic, exp_fop, exp_fa, exp_fb, exp_fr;

   function automatic void ref_calc(input logic [3:0] op, input int av, input int bv,
                                    input int ci, output bit legal, output int er,
                                    output int ecy, output bit chk_c);
      legal = 1'b1; er = 0; ecy = 0; chk_c = 1'b0;
      case (op)
         4'b0000: er = av & bv;
         4'b0001: er = av | bv;
         4'b0010: begin er = (av + bv + ci) % MOD; ecy = (av + bv + ci) / MOD; chk_c = 1'b1; end
         4'b0110: begin
            er = (av + (MOD - 1 - bv) + ci) % MOD;
            ecy = (av + (MOD - 1 - bv) + ci) / MOD;
            chk_c = 1'b1;
         end
         4'b1100: er = (MOD - 1) - (av | bv);
         default: legal = 1'b0;
      endcase
   endfunction

   function automatic int sat_inc(input int v);
      return (v < m_max) ? v + 1 : v;
   endfunction

   task automatic model_reset_outputs();
      exp_cv = 0; exp_cp = 0; exp_fs = 0;
      exp_pc = 0; exp_ec = 0; exp_ic = 0;
      exp_fop = 0; exp_fa = 0; exp_fb = 0; exp_fr = 0;
      exp_q.delete();
   endtask

   // Applies one rising edge to the model, using the inputs held across that edge.
   task automatic model_edge();
      bit   fail_now, legal, chk_c;
      int   er, ecy;
      txn_t t;
      exp_cv = 0; exp_cp = 0;
      if (reset) begin
         model_reset_outputs();
         m_st = 0;
         return;
      end
      if (clear) begin
         model_reset_outputs();
         if (m_st == 2) m_st = 0;
         else if (m_st == 0 && enable) m_st = 1;
         else if (m_st == 1 && !enable) m_st = 0;
         return;
      end
      fail_now = 0;
      if (exp_q.size() > 0) begin
         t = exp_q.pop_front();
         exp_cv = 1; exp_cp = t.pass;
         if (t.pass) exp_pc = sat_inc(exp_pc);
         else begin
            exp_ec = sat_inc(exp_ec);
            fail_now = 1;
            if (!exp_fs && m_st != 2) begin
               exp_fs = 1; exp_fop = t.op; exp_fa = t.av; exp_fb = t.bv; exp_fr = t.res;
            end
         end
      end
      if (m_st == 1 && enable && in_valid) begin
         ref_calc(ALUOp, int'(a), int'(b), int'(CarryIn), legal, er, ecy, chk_c);
         if (legal) begin
            t.op = ALUOp; t.av = int'(a); t.bv = int'(b); t.res = int'(Result);
            t.pass = (int'(Result) == er) && (!chk_c || int'(CarryOut) == ecy);
            exp_q.push_back(t);
         end else begin
            exp_ic = sat_inc(exp_ic);
         end
      end
      case (m_st)
         0: if (enable) m_st = 1;
         1: if (m_halt && fail_now) m_st = 2; else if (!enable) m_st = 0;
         default: ;
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   task automatic compare_all();
      check("chk_valid", 32'(o_cv), 32'(exp_cv));
      if (exp_cv) check("chk_pass", 32'(o_cp), 32'(exp_cp));
      check("pass_count", 32'(o_pc), exp_pc);
      check("err_count", 32'(o_ec), exp_ec);
      check("illegal_count", 32'(o_ic), exp_ic);
      check("fail_seen", 32'(o_fs), 32'(exp_fs));
      check("fail_op", 32'(o_fop), exp_fop);
      check("fail_a", 32'(o_fa), exp_fa);
      check("fail_b", 32'(o_fb), exp_fb);
      check("fail_result", 32'(o_fr), exp_fr);
      check("halted", 32'(o_hl), 32'(m_st == 2));
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
      model_edge();
      compare_all();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic drive(input logic [3:0] op, input int av, input int bv, input int ci,
                        input int res, input int cy);
      in_valid = 1'b1; ALUOp = op; a = W'(av); b = W'(bv);
      CarryIn = ci[0]; Result = W'(res); CarryOut = cy[0];
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic start_phase(input logic [1:0] s, input bit halt, input int max);
      sel = s; m_halt = halt; m_max = max;
      enable = 1'b0; clear = 1'b0; in_valid = 1'b0; reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      check("rst_chk_valid", 32'(o_cv), 0);
      check("rst_pass_count", 32'(o_pc), 0);
      check("rst_err_count", 32'(o_ec), 0);
      check("rst_illegal_count", 32'(o_ic), 0);
      check("rst_fail_seen", 32'(o_fs), 0);
      check("rst_halted", 32'(o_hl), 0);
      enable = 1'b1;
      idle(1);
   endtask

   task automatic rand_run(input int n);
      logic [3:0] ops[5];
      bit   legal, chk_c;
      int   er, ecy;
      ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110; ops[4] = 4'b1100;
      repeat (n) begin
         enable   = ($urandom_range(0, 19) != 0);
         clear    = ($urandom_range(0, 49) == 0);
         in_valid = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 9) < 9) ALUOp = ops[$urandom_range(0, 4)];
         else                         ALUOp = 4'($urandom_range(0, 15));
         a = W'($urandom_range(0, MOD - 1));
         b = W'($urandom_range(0, MOD - 1));
         CarryIn = 1'($urandom_range(0, 1));
         ref_calc(ALUOp, int'(a), int'(b), int'(CarryIn), legal, er, ecy, chk_c);
         if ($urandom_range(0, 3) != 0) begin
            Result   = W'(er);
            CarryOut = chk_c ? ecy[0] : 1'($urandom_range(0, 1));
         end else begin
            Result   = W'($urandom_range(0, MOD - 1));
            CarryOut = 1'($urandom_range(0, 1));
         end
         cycle();
      end
      clear = 1'b0; enable = 1'b1; in_valid = 1'b0;
      idle(3);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      m_st = 0; m_halt = 0; m_max = 255;
      model_reset_outputs();

      // Default instance: logic ops, arithmetic, failure capture, illegal op
      start_phase(2'd0, 1'b0, 255);
      drive(4'b0000, 1, 2, 0, 0, 0);
      drive(4'b0001, 1, 2, 0, 3, 0);
      drive(4'b1100, 1, 2, 0, 60, 0);
      idle(2);
      check("tp1_pass_count", 32'(o_pc), 3);
      check("tp1_err_count", 32'(o_ec), 0);
      drive(4'b0010, 1, 2, 0, 3, 0);
      drive(4'b0010, 1, 2, 1, 4, 0);
      drive(4'b0110, 1, 2, 1, 63, 0);
      idle(2);
      check("tp2_pass_count", 32'(o_pc), 6);
      check("tp2_err_count", 32'(o_ec), 0);
      drive(4'b0010, 63, 1, 0, 0, 0);
      idle(2);
      check("tp3_err_count", 32'(o_ec), 1);
      check("tp3_fail_seen", 32'(o_fs), 1);
      check("tp3_fail_op", 32'(o_fop), 2);
      check("tp3_fail_a", 32'(o_fa), 63);
      check("tp3_fail_b", 32'(o_fb), 1);
      check("tp3_fail_result", 32'(o_fr), 0);
      drive(4'b0000, 5, 3, 0, 7, 0);
      idle(2);
      check("tp3_err_count2", 32'(o_ec), 2);
      check("tp3_keep_fail_a", 32'(o_fa), 63);
      check("tp3_keep_fail_op", 32'(o_fop), 2);
      drive(4'b0111, 1, 2, 0, 0, 0);
      idle(2);
      check("tp4_illegal_count", 32'(o_ic), 1);
      check("tp4_pass_count", 32'(o_pc), 6);
      check("tp4_err_count", 32'(o_ec), 2);
      rand_run(400);

      // Halt-on-error instance
      start_phase(2'd1, 1'b1, 255);
      drive(4'b0010, 63, 1, 0, 0, 0);
      repeat (5) drive(4'b0000, 1, 2, 0, 0, 0);
      idle(3);
      check("halt_halted", 32'(o_hl), 1);
      check("halt_err_count", 32'(o_ec), 1);
      check("halt_pass_count", 32'(o_pc), 1);
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      check("clr_pass_count", 32'(o_pc), 0);
      check("clr_err_count", 32'(o_ec), 0);
      check("clr_illegal_count", 32'(o_ic), 0);
      check("clr_halted", 32'(o_hl), 0);
      check("clr_fail_seen", 32'(o_fs), 0);
      rand_run(250);

      // 2-bit counter instance: saturation and reset with work in flight
      start_phase(2'd2, 1'b0, 3);
      repeat (5) drive(4'b0001, 1, 2, 0, 3, 0);
      idle(2);
      check("sat_pass_count", 32'(o_pc), 3);
      drive(4'b0001, 1, 2, 0, 3, 0);
      drive(4'b0001, 1, 2, 0, 3, 0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      idle(3);
      check("rstfl_chk_valid", 32'(o_cv), 0);
      check("rstfl_pass_count", 32'(o_pc), 0);
      check("rstfl_fail_seen", 32'(o_fs), 0);
      rand_run(250);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
